// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over a programmable window of valid
// samples from the upstream adder and hands the count off through a valid/ready port.
module stoch_to_bin #(
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CWIDTH-1:0] win_len,
    input  logic              abort,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CWIDTH:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t            state_r;
    logic [CWIDTH:0]   acc_r;
    logic [CWIDTH-1:0] rem_r;
    logic [CWIDTH:0]   result_r;
    logic              busy_r;
    logic              res_valid_r;
    logic [CWIDTH:0]   acc_inc_s;
    logic              last_s;

    // Running count including the current sample, and end-of-window detect.
    always_comb begin
        acc_inc_s = acc_r + {{CWIDTH{1'b0}}, in_bit};
        last_s    = (rem_r == {CWIDTH{1'b0}});
    end

    // Conversion state machine with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {(CWIDTH+1){1'b0}};
            rem_r       <= {CWIDTH{1'b0}};
            result_r    <= {(CWIDTH+1){1'b0}};
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rem_r   <= win_len;
                        acc_r   <= {(CWIDTH+1){1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort wins over a sample arriving in the same cycle
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (in_valid) begin
                        acc_r <= acc_inc_s;
                        if (last_s) begin
                            result_r    <= acc_inc_s;
                            busy_r      <= 1'b0;
                            res_valid_r <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            rem_r <= rem_r - {{(CWIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        if (start) begin
                            rem_r   <= win_len;
                            acc_r   <= {(CWIDTH+1){1'b0}};
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Randomised bench for stoch_to_bin: a per-window count of valid ones predicts
// result value and completion cycle; control-path scenarios are checked cycle by cycle.
module tb_stoch_to_bin;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] win_len;
    logic       abort;
    logic       in_bit;
    logic       in_valid;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] result;

    int passed = 0;
    int total  = 0;

    stoch_to_bin #(.CWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .abort(abort),
        .in_bit(in_bit), .in_valid(in_valid), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a start in the current cycle (cycle 0 of a conversion).
    task automatic start_conv(input int wl, input logic rdy);
        win_len   = 8'(wl);
        start     = 1'b1;
        abort     = 1'b0;
        res_ready = rdy;
    endtask

    // Drive one window from cycle 1 and compare against a count of valid ones.
    // vm: 0 always valid, 1 alternate starting valid, 2 random; bm: 0 zeros, 1 ones, 2 random.
    task automatic run_body(input int wl, input int vm, input int bm, input logic rdy,
                            output int ones);
        int  nv;
        int  c;
        bit  done;
        logic v;
        logic b;
        nv = 0; ones = 0; c = 0; done = 0;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
            res_ready = rdy;
            if (nv == wl + 1) begin
                total++;
                if (res_valid !== 1'b1 || busy !== 1'b0 || result !== 9'(ones))
                    $display("FAIL done_c%0d wl=%0d: rv=%b busy=%b result=%0d, required rv=1 busy=0 result=%0d",
                             c, wl, res_valid, busy, result, ones);
                else passed++;
                in_valid = 1'b0;
                done = 1;
            end else begin
                total++;
                if (busy !== 1'b1 || res_valid !== 1'b0)
                    $display("FAIL running_c%0d wl=%0d: busy=%b rv=%b, required busy=1 rv=0",
                             c, wl, busy, res_valid);
                else passed++;
                v = (vm == 0) ? 1'b1 : (vm == 1) ? logic'(c % 2) : logic'($urandom_range(0, 1));
                b = (bm == 0) ? 1'b0 : (bm == 1) ? 1'b1 : logic'($urandom_range(0, 1));
                in_valid = v;
                in_bit   = b;
                if (v) begin
                    nv++;
                    ones += int'(b);
                end
            end
        end
        if (!done) begin
            total++;
            $display("FAIL timeout wl=%0d: window never closed after %0d cycles", wl, c);
        end
    endtask

    // Accept the held result and confirm it drops back to IDLE with result retained.
    task automatic handshake(input int exp_res);
        res_ready = 1'b1;
        start     = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || result !== 9'(exp_res))
            $display("FAIL after_hs: rv=%b busy=%b result=%0d, required rv=0 busy=0 result=%0d",
                     res_valid, busy, result, exp_res);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || result !== 9'd0)
            $display("FAIL reset: busy=%b rv=%b result=%0d, required 0 0 0", busy, res_valid, result);
        else passed++;
    endtask

    task automatic test_full_window();
        int ones;
        start_conv(15, 1'b1);
        run_body(15, 0, 1, 1'b1, ones);
        total++;
        if (ones != 16) $display("FAIL full_window_model: count=%0d, required 16", ones);
        else passed++;
        // res_ready held high: res_valid must last exactly one cycle
        @(posedge clk); #1;
        total++;
        if (res_valid !== 1'b0 || result !== 9'd16)
            $display("FAIL full_window_pulse: rv=%b result=%0d, required rv=0 result=16", res_valid, result);
        else passed++;
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        int ones;
        start_conv(31, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b1;
            in_bit   = logic'($urandom_range(0, 1));
            abort    = (c == 10);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || result !== 9'd16)
            $display("FAIL abort_idle: busy=%b rv=%b result=%0d, required 0 0 16", busy, res_valid, result);
        else passed++;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || result !== 9'd16)
                $display("FAIL abort_quiet_%0d: rv=%b busy=%b result=%0d, required 0 0 16",
                         c, res_valid, busy, result);
            else passed++;
        end
        start_conv(5, 1'b0);
        run_body(5, 0, 2, 1'b0, ones);
        handshake(ones);
    endtask

    task automatic test_extremes();
        int ones;
        start_conv(255, 1'b0);
        run_body(255, 0, 0, 1'b0, ones);
        handshake(0);
        start_conv(255, 1'b0);
        run_body(255, 0, 1, 1'b0, ones);
        total++;
        if (result !== 9'd256) $display("FAIL max_window: result=%0d, required 256", result);
        else passed++;
        handshake(256);
        start_conv(0, 1'b0);
        run_body(0, 0, 1, 1'b0, ones);
        handshake(1);
    endtask

    task automatic test_stalls();
        int ones;
        start_conv(7, 1'b0);
        run_body(7, 1, 1, 1'b0, ones);
        total++;
        if (ones != 8 || result !== 9'd8) $display("FAIL stall_count: result=%0d, required 8", result);
        else passed++;
        handshake(8);
        for (int k = 0; k < 6; k++) begin
            int wl;
            wl = $urandom_range(0, 40);
            start_conv(wl, 1'b0);
            run_body(wl, (k % 2) + 1, 2, 1'b0, ones);
            handshake(ones);
        end
    endtask

    task automatic test_backpressure();
        int ones;
        int held;
        start_conv(9, 1'b0);
        run_body(9, 0, 2, 1'b0, held);
        for (int c = 0; c < 10; c++) begin
            start   = logic'(c % 2);
            abort   = logic'($urandom_range(0, 1));
            win_len = 8'($urandom_range(0, 255));
            res_ready = 1'b0;
            @(posedge clk); #1;
            total++;
            if (res_valid !== 1'b1 || busy !== 1'b0 || result !== 9'(held))
                $display("FAIL backpressure_%0d: rv=%b busy=%b result=%0d, required 1 0 %0d",
                         c, res_valid, busy, result, held);
            else passed++;
        end
        abort = 1'b0;
        start_conv(3, 1'b1);
        run_body(3, 0, 1, 1'b0, ones);
        handshake(4);
    endtask

    task automatic test_back_to_back();
        int ones;
        int wl;
        wl = $urandom_range(0, 12);
        start_conv(wl, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_body(wl, 0, 2, 1'b0, ones);
            wl = $urandom_range(0, 12);
            start_conv(wl, 1'b1);
        end
        run_body(wl, 2, 2, 1'b0, ones);
        handshake(ones);
    endtask

    task automatic test_reset_mid();
        int ones;
        start_conv(20, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || result !== 9'd0)
            $display("FAIL reset_run: busy=%b rv=%b result=%0d, required 0 0 0", busy, res_valid, result);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start_conv(2, 1'b0);
        run_body(2, 0, 1, 1'b0, ones);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || result !== 9'd0)
            $display("FAIL reset_hold: busy=%b rv=%b result=%0d, required 0 0 0", busy, res_valid, result);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start_conv(4, 1'b0);
        run_body(4, 0, 2, 1'b0, ones);
        handshake(ones);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = 8'd0; abort = 1'b0;
        in_bit = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_full_window();
        test_abort();
        test_extremes();
        test_stalls();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
